pipe_stage_reg: RTL and testbench

//  Parametrised Y86-64 inter-stage pipeline register, replacing per-stage hand-coded registers (F->D, D->E, E->M, M->W).

---
 rtl/pipe_stage_reg_if.sv | 61 ++++++
 rtl/pipe_stage_reg.sv | 167 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Y86-64 pipeline register bus.
// Upstream fields in, registered fields and status out.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 136,
  parameter int CNT_W  = 16
);

  logic [2:0]        in_stat;
  logic [3:0]        in_icode;
  logic [3:0]        in_ifun;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic              bubble;

  logic [2:0]        out_stat;
  logic [3:0]        out_icode;
  logic [3:0]        out_ifun;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
  logic              stall_timeout;
  logic              conflict_err;

  modport master (
    output in_stat,
    output in_icode,
    output in_ifun,
    output in_data,
    output stall,
    output bubble,
    input  out_stat,
    input  out_icode,
    input  out_ifun,
    input  out_data,
    input  out_valid,
    input  stall_cnt,
    input  bubble_cnt,
    input  stall_timeout,
    input  conflict_err
  );

  modport slave (
    input  in_stat,
    input  in_icode,
    input  in_ifun,
    input  in_data,
    input  stall,
    input  bubble,
    output out_stat,
    output out_icode,
    output out_ifun,
    output out_data,
    output out_valid,
    output stall_cnt,
    output bubble_cnt,
    output stall_timeout,
    output conflict_err
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Y86-64 inter-stage pipeline register with stall/bubble,
// usage counters, stall watchdog and conflict flag.
`default_nettype none

module pipe_stage_reg #(
  parameter int         DATA_W          = 136,
  parameter int         CNT_W           = 16,
  parameter int         STALL_LIMIT     = 64,
  parameter bit         CLEAR_ON_BUBBLE = 1'b1,
  parameter logic [3:0] NOP_ICODE       = 4'h1,
  parameter logic [3:0] FNONE           = 4'h0,
  parameter logic [2:0] STAT_AOK        = 3'd1
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_reg_if.slave  bus
);

  localparam logic [1:0] M_LOAD   = 2'd0;
  localparam logic [1:0] M_STALL  = 2'd1;
  localparam logic [1:0] M_BUBBLE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   =
    CNT_W'(STALL_LIMIT);

  logic              is_bub;
  logic              is_stl;
  logic              is_ld;
  logic [1:0]        mode;

  logic [2:0]        stat_q;
  logic [3:0]        icode_q;
  logic [3:0]        ifun_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  bubble_cnt_q;
  logic [CNT_W-1:0]  run_q;
  logic [CNT_W-1:0]  run_nxt;
  logic              timeout_q;
  logic              conflict_q;

  // Bubble beats stall, so the three modes are one-hot.
  assign is_bub = bus.bubble;
  assign is_stl = bus.stall & ~bus.bubble;
  assign is_ld  = ~bus.stall & ~bus.bubble;

  // Encode the per-cycle update mode.
  always_comb begin
    mode = M_LOAD;
    unique case (1'b1)
      is_bub:  mode = M_BUBBLE;
      is_stl:  mode = M_STALL;
      is_ld:   mode = M_LOAD;
      default: mode = M_LOAD;
    endcase
  end

  // Control fields: load, hold, or become a NOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q  <= STAT_AOK;
      icode_q <= NOP_ICODE;
      ifun_q  <= FNONE;
      valid_q <= 1'b0;
    end else begin
      unique case (mode)
        M_BUBBLE: begin
          stat_q  <= STAT_AOK;
          icode_q <= NOP_ICODE;
          ifun_q  <= FNONE;
          valid_q <= 1'b0;
        end
        M_LOAD: begin
          stat_q  <= bus.in_stat;
          icode_q <= bus.in_icode;
          ifun_q  <= bus.in_ifun;
          valid_q <= 1'b1;
        end
        default: begin
          stat_q  <= stat_q;
          icode_q <= icode_q;
          ifun_q  <= ifun_q;
          valid_q <= valid_q;
        end
      endcase
    end
  end

  // Payload: a bubble either zeroes it or keeps
  // the last loaded value, depending on the build.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      unique case (mode)
        M_LOAD: data_q <= bus.in_data;
        M_BUBBLE: begin
          if (CLEAR_ON_BUBBLE)
            data_q <= '0;
          else
            data_q <= data_q;
        end
        default: data_q <= data_q;
      endcase
    end
  end

  // Saturating lifetime counts of stall and bubble cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (is_stl && stall_cnt_q != CNT_MAX)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (is_bub && bubble_cnt_q != CNT_MAX)
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  // Length of the current stall run after this edge.
  always_comb begin
    run_nxt = '0;
    if (is_stl) begin
      if (run_q != CNT_MAX)
        run_nxt = run_q + 1'b1;
      else
        run_nxt = run_q;
    end
  end

  // Watchdog: flag once the run reaches the limit;
  // any load or bubble restarts the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      run_q     <= run_nxt;
      timeout_q <= is_stl && (run_nxt >= LIMIT);
    end
  end

  // Sticky record of contradictory stall+bubble requests.
  always_ff @(posedge clk) begin
    if (reset)
      conflict_q <= 1'b0;
    else if (bus.stall && bus.bubble)
      conflict_q <= 1'b1;
  end

  assign bus.out_stat      = stat_q;
  assign bus.out_icode     = icode_q;
  assign bus.out_ifun      = ifun_q;
  assign bus.out_data      = data_q;
  assign bus.out_valid     = valid_q;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.bubble_cnt    = bubble_cnt_q;
  assign bus.stall_timeout = timeout_q;
  assign bus.conflict_err  = conflict_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: default build plus a
// small-counter, hold-on-bubble build.
module tb_pipe_stage_reg;

  logic clk;
  logic rst_a;
  logic rst_b;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_reg_if #(.DATA_W(136), .CNT_W(16)) ifa ();
  pipe_stage_reg_if #(.DATA_W(136), .CNT_W(3))  ifb ();

  pipe_stage_reg #(
    .DATA_W(136), .CNT_W(16), .STALL_LIMIT(64),
    .CLEAR_ON_BUBBLE(1'b1)
  ) u_a (
    .clk(clk), .reset(rst_a), .bus(ifa)
  );

  pipe_stage_reg #(
    .DATA_W(136), .CNT_W(3), .STALL_LIMIT(4),
    .CLEAR_ON_BUBBLE(1'b0)
  ) u_b (
    .clk(clk), .reset(rst_b), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        bub;
    logic [3:0]  icode;
    logic [63:0] data;
    logic [3:0]  e_icode;
    logic        e_valid;
    logic [63:0] e_data;
    logic [15:0] e_scnt;
    logic [15:0] e_bcnt;
    logic        e_conf;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(
    input logic rst, input logic stl, input logic bub,
    input logic [3:0] icode, input logic [63:0] data,
    input logic [3:0] e_icode, input logic e_valid,
    input logic [63:0] e_data, input int e_scnt,
    input int e_bcnt, input logic e_conf);
    vec_t v;
    v.rst = rst; v.stl = stl; v.bub = bub;
    v.icode = icode; v.data = data;
    v.e_icode = e_icode; v.e_valid = e_valid;
    v.e_data = e_data;
    v.e_scnt = 16'(e_scnt); v.e_bcnt = 16'(e_bcnt);
    v.e_conf = e_conf;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [135:0] act,
                     input logic [135:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [135:0] rnd136();
    return {$urandom(), $urandom(), $urandom(),
            $urandom(), 8'($urandom())};
  endfunction

  task automatic drive_a(input vec_t v);
    logic [3:0] ic;
    rst_a      = v.rst;
    ifa.stall  = v.stl;
    ifa.bubble = v.bub;
    if (v.rst || v.stl || v.bub) begin
      ifa.in_icode = 4'($urandom());
      ifa.in_ifun  = 4'($urandom());
      ifa.in_stat  = 3'($urandom());
      ifa.in_data  = rnd136();
    end else begin
      ic = v.icode;
      ifa.in_icode = ic;
      ifa.in_ifun  = ic - 4'd1;
      ifa.in_stat  = ic[2:0];
      ifa.in_data  = {72'd0, v.data};
    end
  endtask

  task automatic check_a(input int idx);
    vec_t e;
    logic [3:0] ei;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e  = exp_q.pop_front();
    ei = e.e_icode;
    chk($sformatf("r%0d_icode", idx), 136'(ifa.out_icode), 136'(ei));
    chk($sformatf("r%0d_ifun", idx), 136'(ifa.out_ifun), 136'(ei - 4'd1));
    chk($sformatf("r%0d_stat", idx), 136'(ifa.out_stat), 136'(ei[2:0]));
    chk($sformatf("r%0d_data", idx), ifa.out_data, {72'd0, e.e_data});
    chk($sformatf("r%0d_valid", idx), 136'(ifa.out_valid), 136'(e.e_valid));
    chk($sformatf("r%0d_scnt", idx), 136'(ifa.stall_cnt), 136'(e.e_scnt));
    chk($sformatf("r%0d_bcnt", idx), 136'(ifa.bubble_cnt), 136'(e.e_bcnt));
    chk($sformatf("r%0d_conf", idx), 136'(ifa.conflict_err), 136'(e.e_conf));
    chk($sformatf("r%0d_tmo", idx), 136'(ifa.stall_timeout), 136'(0));
  endtask

  task automatic step_b(input logic stl, input logic bub,
                        input logic [3:0] ic,
                        input logic [63:0] d);
    rst_b        = 1'b0;
    ifb.stall    = stl;
    ifb.bubble   = bub;
    ifb.in_icode = ic;
    ifb.in_ifun  = ic - 4'd1;
    ifb.in_stat  = ic[2:0];
    ifb.in_data  = {72'd0, d};
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  ic;
    logic [63:0] d;

    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.stall = 1'b0; ifa.bubble = 1'b0;
    ifa.in_icode = '0; ifa.in_ifun = '0;
    ifa.in_stat = '0;  ifa.in_data = '0;
    ifb.stall = 1'b0; ifb.bubble = 1'b0;
    ifb.in_icode = '0; ifb.in_ifun = '0;
    ifb.in_stat = '0;  ifb.in_data = '0;

    vecs.push_back(mk(1,0,0, 0,0, 1,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0, 0,0, 1,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0, 6,'hAB, 6,1,'hAB, 0,0,0));
    vecs.push_back(mk(0,0,0, 6,'hAB, 6,1,'hAB, 0,0,0));
    vecs.push_back(mk(0,0,0, 3,'h1234, 3,1,'h1234, 0,0,0));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk(0,1,0, 0,0, 3,1,'h1234, k,0,0));
    vecs.push_back(mk(0,0,1, 0,0, 1,0,0, 5,1,0));
    vecs.push_back(mk(0,0,0, 7,64'hDEADBEEF_CAFEF00D,
                      7,1,64'hDEADBEEF_CAFEF00D, 5,1,0));
    vecs.push_back(mk(0,1,1, 0,0, 1,0,0, 5,2,1));
    for (int k = 0; k < 10; k++) begin
      ic = 4'(2 + k);
      d  = 64'(k) * 64'h100 + 64'(ic);
      vecs.push_back(mk(0,0,0, ic,d, ic,1,d, 5,2,1));
    end
    vecs.push_back(mk(1,0,0, 0,0, 1,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0, 5,'h55, 5,1,'h55, 0,0,0));
    vecs.push_back(mk(0,1,0, 0,0, 5,1,'h55, 1,0,0));
    vecs.push_back(mk(1,0,0, 0,0, 1,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0, 15,'1, 15,1,'1, 0,0,0));

    foreach (vecs[i]) begin
      drive_a(vecs[i]);
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      check_a(i);
    end

    // Default watchdog boundary: 63 stalls quiet, 64th fires.
    drive_a(mk(0,0,0, 9,'h9, 9,1,'h9, 0,0,0));
    @(posedge clk); #1;
    for (int i = 1; i <= 64; i++) begin
      drive_a(mk(0,1,0, 0,0, 9,1,'h9, 0,0,0));
      @(posedge clk); #1;
      if (i == 63)
        chk("a_tmo_63", 136'(ifa.stall_timeout), 136'(0));
      if (i == 64)
        chk("a_tmo_64", 136'(ifa.stall_timeout), 136'(1));
    end
    chk("a_scnt_64", 136'(ifa.stall_cnt), 136'(64));
    chk("a_hold_icode", 136'(ifa.out_icode), 136'(9));
    drive_a(mk(0,0,0, 4,'h4, 4,1,'h4, 0,0,0));
    @(posedge clk); #1;
    chk("a_tmo_clr", 136'(ifa.stall_timeout), 136'(0));
    chk("a_load_after", 136'(ifa.out_icode), 136'(4));

    // Small build: watchdog at 4, saturation at 7, hold on bubble.
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("b_rst_scnt", 136'(ifb.stall_cnt), 136'(0));
    chk("b_rst_valid", 136'(ifb.out_valid), 136'(0));
    step_b(0, 0, 4'd6, 64'h77);
    chk("b_load_data", ifb.out_data, 136'h77);
    for (int i = 1; i <= 10; i++) begin
      step_b(1, 0, 4'($urandom()), 64'($urandom()));
      if (i == 3)
        chk("b_tmo_3", 136'(ifb.stall_timeout), 136'(0));
      if (i == 4)
        chk("b_tmo_4", 136'(ifb.stall_timeout), 136'(1));
      if (i == 7)
        chk("b_scnt_7", 136'(ifb.stall_cnt), 136'(7));
    end
    chk("b_scnt_sat", 136'(ifb.stall_cnt), 136'(7));
    chk("b_tmo_long", 136'(ifb.stall_timeout), 136'(1));
    chk("b_stall_data", ifb.out_data, 136'h77);
    step_b(0, 0, 4'd2, 64'h99);
    chk("b_tmo_clr", 136'(ifb.stall_timeout), 136'(0));
    step_b(0, 1, 4'd8, 64'h1111);
    chk("b_bub_data", ifb.out_data, 136'h99);
    chk("b_bub_icode", 136'(ifb.out_icode), 136'(1));
    chk("b_bub_ifun", 136'(ifb.out_ifun), 136'(0));
    chk("b_bub_valid", 136'(ifb.out_valid), 136'(0));
    chk("b_bcnt_1", 136'(ifb.bubble_cnt), 136'(1));
    for (int i = 0; i < 8; i++)
      step_b(0, 1, 4'd8, 64'h2222);
    chk("b_bcnt_sat", 136'(ifb.bubble_cnt), 136'(7));
    chk("b_bub_data2", ifb.out_data, 136'h99);
    step_b(1, 1, 4'd8, 64'h3333);
    chk("b_conf", 136'(ifb.conflict_err), 136'(1));
    chk("b_conf_scnt", 136'(ifb.stall_cnt), 136'(7));
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("b_conf_rst", 136'(ifb.conflict_err), 136'(0));
    chk("b_bcnt_rst", 136'(ifb.bubble_cnt), 136'(0));
    chk("b_data_rst", ifb.out_data, 136'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
